// File: rtl/program_loader_pkg.sv
// Shared machine parameters seen by both the processor and the boot loader.
package Isa;
  localparam int INSTRUCTION_SIZE     = 16;
  localparam int MEMORY_ADDRESS_WIDTH = 8;
  localparam int MEMORY_DEPTH         = 1 << MEMORY_ADDRESS_WIDTH;
endpackage

// File: rtl/program_loader_idle.sv
// Idle-cycle watchdog: counts consecutive enabled cycles without a clear and
// flags the cycle whose edge completes TIMEOUT_CYCLES idle cycles.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // Count idle cycles; any transfer or leaving the timed states restarts it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (!i_enable || i_clear) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = i_enable && !i_clear && (r_count == LAST);
endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a byte-serial image (count, word bytes, XOR checksum),
// writes 16-bit words to RAM from address 0 and releases the processor reset
// only after the checksum matches. Errors and success are sticky until reset.
//
// Handshake: a byte moves on a rising edge where i_rx_valid && o_rx_ready;
// o_rx_ready is decoded from state only and never depends on i_rx_valid.
import Isa::*;

module program_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_rx_valid,
  input  logic [7:0]                      i_rx_data,
  output logic                            o_rx_ready,
  output logic                            o_write_enable,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] o_address,
  output logic [INSTRUCTION_SIZE-1:0]     o_write_data,
  output logic                            o_cpu_reset_n,
  output logic                            o_done,
  output logic                            o_error,
  output logic [2:0]                      o_debug_state
);
  localparam int LOADER_BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HIGH, S_LOW, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                            r_state;
  logic [8:0]                        r_remaining;
  logic [LOADER_BYTE_WIDTH-1:0]      r_high;
  logic [LOADER_BYTE_WIDTH-1:0]      r_checksum;
  logic [MEMORY_ADDRESS_WIDTH-1:0]   r_address;
  logic [INSTRUCTION_SIZE-1:0]       r_write_data;
  logic                              r_write_enable;
  logic                              r_cpu_reset_n;
  logic                              r_done;
  logic                              r_error;

  logic w_rx_ready;
  logic w_transfer;
  logic w_timer_enable;
  logic w_timer_expired;

  assign w_rx_ready = (r_state == S_COUNT) || (r_state == S_HIGH) ||
                      (r_state == S_LOW)   || (r_state == S_CHECK);
  assign w_transfer = i_rx_valid && w_rx_ready;
  // COUNT is excluded so the loader can wait forever for an image to start.
  assign w_timer_enable = (r_state == S_HIGH) || (r_state == S_LOW) ||
                          (r_state == S_CHECK);

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_transfer),
    .i_enable  (w_timer_enable),
    .o_expired (w_timer_expired)
  );

  // Load sequencer with registered RAM write port and status outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_remaining    <= '0;
      r_high         <= '0;
      r_checksum     <= '0;
      r_address      <= '0;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
      r_cpu_reset_n  <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_COUNT;
        S_COUNT: begin
          if (w_transfer) begin
            // A zero count stands for a full 256-word image.
            r_remaining <= (i_rx_data == '0) ? 9'd256 : {1'b0, i_rx_data};
            r_address   <= '0;
            r_checksum  <= '0;
            r_state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_transfer) begin
            r_high     <= i_rx_data;
            r_checksum <= r_checksum ^ i_rx_data;
            r_state    <= S_LOW;
          end else if (w_timer_expired) begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_LOW: begin
          if (w_transfer) begin
            r_write_data   <= {r_high, i_rx_data};
            r_write_enable <= 1'b1;
            r_checksum     <= r_checksum ^ i_rx_data;
            r_state        <= S_WRITE;
          end else if (w_timer_expired) begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_WRITE: begin
          // Address advances only after the strobe cycle; wrap after the
          // 256th word is harmless because it is not used again.
          r_address   <= r_address + MEMORY_ADDRESS_WIDTH'(1);
          r_remaining <= r_remaining - 9'd1;
          r_state     <= (r_remaining == 9'd1) ? S_CHECK : S_HIGH;
        end
        S_CHECK: begin
          if (w_transfer) begin
            if (i_rx_data == r_checksum) begin
              r_done        <= 1'b1;
              r_cpu_reset_n <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end else if (w_timer_expired) begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  assign o_rx_ready     = w_rx_ready;
  assign o_write_enable = r_write_enable;
  assign o_address      = r_address;
  assign o_write_data   = r_write_data;
  assign o_cpu_reset_n  = r_cpu_reset_n;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_debug_state  = r_state;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random frames and gaps, reference writes derived
// from the frame bytes, write-port monitor with an expected queue.
module tb_program_loader;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        o_rx_ready, o_write_enable, o_cpu_reset_n, o_done, o_error;
  logic [7:0]  o_address;
  logic [15:0] o_write_data;
  logic [2:0]  o_debug_state;

  logic [23:0] exp_q[$];
  logic [7:0]  frame[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic        prev_we = 1'b0;
  bit          good;

  program_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .o_rx_ready     (o_rx_ready),
    .o_write_enable (o_write_enable),
    .o_address      (o_address),
    .o_write_data   (o_write_data),
    .o_cpu_reset_n  (o_cpu_reset_n),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_debug_state  (o_debug_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr, word}
  always @(negedge clk) begin
    if (rst_n && o_write_enable) begin
      if (exp_q.size() == 0) check("spurious_write", o_write_enable, 1'b0);
      else check("write_word", {o_address, o_write_data}, exp_q.pop_front());
      check("ready_in_write", o_rx_ready, 1'b0);
      check("we_one_cycle", prev_we, 1'b0);
    end
    prev_we = o_write_enable;
  end

  // reference: image meaning straight from the frame rules
  task automatic model_frame(output bit ok);
    int n;
    logic [7:0] x;
    n = (frame[0] == 8'h00) ? 256 : int'(frame[0]);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), frame[1 + 2*i], frame[2 + 2*i]});
      x = x ^ frame[1 + 2*i] ^ frame[2 + 2*i];
    end
    ok = (frame[2*n + 1] == x);
  endtask

  task automatic build_nominal(input bit corrupt);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'h03);
    frame.push_back(8'h31); frame.push_back(8'h01);
    frame.push_back(8'h30); frame.push_back(8'h00);
    frame.push_back(8'h00); frame.push_back(8'h00);
    x = 8'h31 ^ 8'h01 ^ 8'h30;
    frame.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic build_random(input logic [7:0] count, input bit corrupt);
    int n;
    logic [7:0] b, x;
    n = (count == 8'h00) ? 256 : int'(count);
    frame.delete();
    frame.push_back(count);
    x = 8'h00;
    for (int i = 0; i < 2*n; i++) begin
      b = 8'($urandom_range(255, 0));
      frame.push_back(b);
      x = x ^ b;
    end
    frame.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
  endtask

  // driver: optional idle gap, then hold valid until ready; returns on the
  // falling edge after the transfer edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g, w;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    w = 0;
    while (!o_rx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("rx_ready_wait", w, 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input int n_bytes);
    for (int i = 0; i < n_bytes; i++) send_byte(frame[i], max_gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {o_rx_ready, o_write_enable, o_address, o_write_data,
                            o_cpu_reset_n, o_done, o_error}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_ready", o_rx_ready, 1'b0);
    @(negedge clk);
    check("count_ready", o_rx_ready, 1'b1);
  endtask

  task automatic check_outcome(input bit ok);
    check("done", o_done, ok);
    check("cpu_reset_n", o_cpu_reset_n, ok);
    check("error", o_error, !ok);
    check("writes_left", exp_q.size(), 0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("terminal_ready", o_rx_ready, 1'b0);
    end
    rx_valid = 1'b0;
    check("sticky_done", o_done, ok);
    check("sticky_error", o_error, !ok);
  endtask

  initial begin
    int n;
    do_reset();

    // nominal load
    build_nominal(1'b0);
    model_frame(good);
    check("nominal_is_good", good, 1'b1);
    send_frame(0, frame.size());
    check_outcome(good);

    // bad checksum: words still written, error raised
    do_reset();
    build_nominal(1'b1);
    model_frame(good);
    send_frame(0, frame.size());
    check_outcome(good);

    // full 256-word image
    do_reset();
    build_random(8'h00, 1'b0);
    model_frame(good);
    send_frame(1, frame.size());
    check_outcome(good);

    // backpressure and gaps on the nominal frame
    for (int k = 0; k < 2; k++) begin
      do_reset();
      build_nominal(1'b0);
      model_frame(good);
      send_frame(TIMEOUT - 6, frame.size());
      check_outcome(good);
    end

    // random frames, random corruption, random gaps
    for (int k = 0; k < 5; k++) begin
      do_reset();
      build_random(8'($urandom_range(12, 1)), 1'($urandom_range(1, 0)));
      model_frame(good);
      send_frame(10, frame.size());
      check_outcome(good);
    end

    // timeout after the high byte of word 1
    do_reset();
    build_nominal(1'b0);
    exp_q.push_back({8'd0, 16'h3101});
    send_frame(0, 4);
    n = 0;
    while (!o_error && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_cpu_reset_n", o_cpu_reset_n, 1'b0);
    check("timeout_ready", o_rx_ready, 1'b0);
    check("timeout_writes_left", exp_q.size(), 0);

    // long wait before the count byte is not an error
    do_reset();
    repeat (1000) @(negedge clk);
    check("idle_wait_error", o_error, 1'b0);
    check("idle_wait_ready", o_rx_ready, 1'b1);
    build_nominal(1'b0);
    model_frame(good);
    send_frame(0, frame.size());
    check_outcome(good);

    // reset in the middle of a load, then reload from address 0
    do_reset();
    build_nominal(1'b0);
    exp_q.push_back({8'd0, 16'h3101});
    exp_q.push_back({8'd1, 16'h3000});
    send_frame(0, 5);
    @(negedge clk);
    check("pre_reset_address", o_address, 8'd2);
    check("pre_reset_writes_left", exp_q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", {o_rx_ready, o_write_enable, o_address, o_write_data,
                                    o_cpu_reset_n, o_done, o_error}, 0);
    do_reset();
    model_frame(good);
    send_frame(3, frame.size());
    check_outcome(good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
